// File: rtl/fetch_seq_pkg.sv
// ----------------------------------------------------------------------------
// fetch_seq_pkg
//   Shared types and constants for the fetch sequencer.
//   cond_t  : 3-bit branch condition codes as encoded in the instruction.
//   state_t : fetch sequencer FSM states.
//   FLAG_*  : bit positions of Z/V/N inside the 3-bit flag register.
// ----------------------------------------------------------------------------
package fetch_seq_pkg;

  typedef enum logic [2:0] {
    NE     = 3'd0,
    EQ     = 3'd1,
    GT     = 3'd2,
    LT     = 3'd3,
    GE     = 3'd4,
    LE     = 3'd5,
    OV     = 3'd6,
    UNCOND = 3'd7
  } cond_t;

  typedef enum logic [1:0] {
    S_FETCH = 2'd0,
    S_ISSUE = 2'd1,
    S_HALT  = 2'd2
  } state_t;

  localparam int FLAG_Z = 2;
  localparam int FLAG_V = 1;
  localparam int FLAG_N = 0;

endpackage

// File: rtl/branch_cond_eval.sv
// ----------------------------------------------------------------------------
// branch_cond_eval
//   Combinational branch condition evaluator.
//   Ports:
//     cond  in  3  condition code (cond_t)
//     flags in  3  flag register {Z,V,N}
//     met   out 1  condition holds for the given flags
// ----------------------------------------------------------------------------
module branch_cond_eval
  import fetch_seq_pkg::*;
(
  input  cond_t      cond,
  input  logic [2:0] flags,
  output logic       met
);

  logic z, v, n;

  assign z = flags[FLAG_Z];
  assign v = flags[FLAG_V];
  assign n = flags[FLAG_N];

  always_comb begin
    met = 1'b0;
    case (cond)
      NE:      met = !z;
      EQ:      met = z;
      GT:      met = !z && !n;
      LT:      met = n;
      GE:      met = z || !n;
      LE:      met = z || n;
      OV:      met = v;
      UNCOND:  met = 1'b1;
      default: met = 1'b0;
    endcase
  end

endmodule

// File: rtl/fetch_sequencer.sv
// ----------------------------------------------------------------------------
// fetch_sequencer
//   Owns the PC, the Z/V/N flag register and the instruction fetch handshake.
//   Computes the next PC (sequential, PC-relative branch, or register target)
//   and parks on HLT.
//
//   Handshake: imem_req stays high in S_FETCH until a cycle in which
//   imem_ready is high; imem_rdata is captured in that same cycle. There is
//   no outstanding-request tracking: a response is only accepted in S_FETCH.
//
//   Optional feature macro: FETCH_TIMEOUT_EN
//     defined   -> fetch watchdog; after TIMEOUT_CYC cycles in S_FETCH without
//                  imem_ready, fetch_err is set (sticky) and the FSM halts.
//     undefined -> no watchdog, fetch_err tied 0, S_FETCH waits forever.
//
//   Ports:
//     clk, rst                 clock, asynchronous active-high reset
//     imem_req/addr            fetch request and address (= pc)
//     imem_ready/rdata         fetch response
//     instr, instr_valid       registered instruction to decode
//     stall                    decode stall (holds S_ISSUE)
//     br_valid/is_reg/cond/imm/reg  branch information from decode
//     halt                     HLT from decode
//     flag_we, flag_in         per-bit flag write {Z,V,N}
//     flags                    flag register {Z,V,N}
//     pc                       current PC
//     br_taken                 1-cycle pulse after a redirecting branch
//     halted                   FSM is in S_HALT
//     fetch_err                watchdog fired (sticky)
//     dbg_state                current FSM state
// ----------------------------------------------------------------------------
module fetch_sequencer
  import fetch_seq_pkg::*;
#(
  parameter logic [15:0] RESET_PC    = 16'h0000,
  parameter int          TIMEOUT_CYC = 15
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [15:0] imem_addr,
  input  logic        imem_ready,
  input  logic [15:0] imem_rdata,
  output logic [15:0] instr,
  output logic        instr_valid,
  input  logic        stall,
  input  logic        br_valid,
  input  logic        br_is_reg,
  input  logic [2:0]  br_cond,
  input  logic [8:0]  br_imm,
  input  logic [15:0] br_reg,
  input  logic        halt,
  input  logic [2:0]  flag_we,
  input  logic [2:0]  flag_in,
  output logic [2:0]  flags,
  output logic [15:0] pc,
  output logic        br_taken,
  output logic        halted,
  output logic        fetch_err,
  output state_t      dbg_state
);

  state_t      state;
  logic [15:0] pc_q;
  logic [15:0] instr_q;
  logic [2:0]  flags_q;
  logic        br_taken_q;

  logic        cond_met;
  logic        met;
  logic [15:0] seq_pc;
  logic [15:0] rel_pc;
  logic [15:0] next_pc;

  // Branches always see the registered flags, never this cycle's write.
  branch_cond_eval u_cond (
    .cond  (cond_t'(br_cond)),
    .flags (flags_q),
    .met   (cond_met)
  );

  assign met     = br_valid && cond_met;
  assign seq_pc  = pc_q + 16'd2;
  // Word offset: sign-extend imm9 and shift left by one.
  assign rel_pc  = seq_pc + {{6{br_imm[8]}}, br_imm, 1'b0};
  assign next_pc = met ? (br_is_reg ? br_reg : rel_pc) : seq_pc;

`ifdef FETCH_TIMEOUT_EN
  logic [3:0] wait_cnt;
  logic       fetch_err_q;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= S_FETCH;
      pc_q       <= RESET_PC;
      instr_q    <= 16'h0000;
      flags_q    <= 3'b000;
      br_taken_q <= 1'b0;
`ifdef FETCH_TIMEOUT_EN
      wait_cnt    <= 4'd0;
      fetch_err_q <= 1'b0;
`endif
    end else begin
      // Flags are writable in every state, bit by bit.
      flags_q    <= (flags_q & ~flag_we) | (flag_in & flag_we);
      br_taken_q <= 1'b0;
      case (state)
        S_FETCH: begin
          if (imem_ready) begin
            instr_q <= imem_rdata;
            state   <= S_ISSUE;
`ifdef FETCH_TIMEOUT_EN
            wait_cnt <= 4'd0;
`endif
          end
`ifdef FETCH_TIMEOUT_EN
          else if (wait_cnt == 4'(TIMEOUT_CYC - 1)) begin
            fetch_err_q <= 1'b1;
            state       <= S_HALT;
          end else begin
            wait_cnt <= wait_cnt + 4'd1;
          end
`endif
        end
        S_ISSUE: begin
          if (!stall) begin
            if (halt) begin
              state <= S_HALT;
            end else begin
              pc_q       <= next_pc;
              br_taken_q <= met;
              state      <= S_FETCH;
`ifdef FETCH_TIMEOUT_EN
              wait_cnt <= 4'd0;
`endif
            end
          end
        end
        S_HALT: state <= S_HALT;
        default: state <= S_FETCH;
      endcase
    end
  end

  // Reset forces state to S_FETCH, so the request is masked while rst is high.
  assign imem_req    = (state == S_FETCH) && !rst;
  assign imem_addr   = pc_q;
  assign instr       = instr_q;
  assign instr_valid = (state == S_ISSUE);
  assign halted      = (state == S_HALT);
  assign flags       = flags_q;
  assign pc          = pc_q;
  assign br_taken    = br_taken_q;
  assign dbg_state   = state;

`ifdef FETCH_TIMEOUT_EN
  assign fetch_err = fetch_err_q;
`else
  assign fetch_err = 1'b0;
`endif

endmodule

// File: tb/tb_fetch_sequencer.sv
// ----------------------------------------------------------------------------
// tb_fetch_sequencer
//   Directed bench for fetch_sequencer. Inputs change 1 time unit after the
//   rising edge, outputs are checked at the same point.
//   Define FETCH_TIMEOUT_EN for both bench and RTL to exercise the watchdog.
// ----------------------------------------------------------------------------
module tb_fetch_sequencer;
  import fetch_seq_pkg::*;

  localparam int TO = 15;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req;
  logic [15:0] imem_addr;
  logic        imem_ready;
  logic [15:0] imem_rdata;
  logic [15:0] instr;
  logic        instr_valid;
  logic        stall;
  logic        br_valid;
  logic        br_is_reg;
  logic [2:0]  br_cond;
  logic [8:0]  br_imm;
  logic [15:0] br_reg;
  logic        halt;
  logic [2:0]  flag_we;
  logic [2:0]  flag_in;
  logic [2:0]  flags;
  logic [15:0] pc;
  logic        br_taken;
  logic        halted;
  logic        fetch_err;
  state_t      dbg_state;

  int n_cmp = 0;
  int n_err = 0;

  // {cond, flags ZVN, expected met}
  logic [6:0] cond_tab [14] = '{
    7'b000_000_1, 7'b000_100_0, 7'b001_000_0, 7'b001_100_1,
    7'b010_000_1, 7'b010_001_0, 7'b011_001_1, 7'b100_001_0,
    7'b100_101_1, 7'b101_000_0, 7'b101_001_1, 7'b110_010_1,
    7'b110_101_0, 7'b111_000_1
  };

  fetch_sequencer #(.RESET_PC(16'h0000), .TIMEOUT_CYC(TO)) dut (
    .clk         (clk),
    .rst         (rst),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ready  (imem_ready),
    .imem_rdata  (imem_rdata),
    .instr       (instr),
    .instr_valid (instr_valid),
    .stall       (stall),
    .br_valid    (br_valid),
    .br_is_reg   (br_is_reg),
    .br_cond     (br_cond),
    .br_imm      (br_imm),
    .br_reg      (br_reg),
    .halt        (halt),
    .flag_we     (flag_we),
    .flag_in     (flag_in),
    .flags       (flags),
    .pc          (pc),
    .br_taken    (br_taken),
    .halted      (halted),
    .fetch_err   (fetch_err),
    .dbg_state   (dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    imem_ready = 1'b0;
    imem_rdata = 16'h0000;
    stall      = 1'b0;
    br_valid   = 1'b0;
    br_is_reg  = 1'b0;
    br_cond    = 3'd0;
    br_imm     = 9'd0;
    br_reg     = 16'h0000;
    halt       = 1'b0;
    flag_we    = 3'b000;
    flag_in    = 3'b000;
  endtask

  task automatic apply_reset();
    clear_inputs();
    rst = 1'b1;
    step();
    rst = 1'b0;
    #1;
  endtask

  // ---------------- driver tasks ----------------
  // Completes a fetch with a same-cycle response.
  task automatic drive_fetch(input logic [15:0] data);
    imem_ready = 1'b1;
    imem_rdata = data;
    step();
    imem_ready = 1'b0;
    imem_rdata = 16'h0000;
  endtask

  // Presents branch information for one S_ISSUE cycle.
  task automatic drive_branch(input logic v, input logic is_reg, input logic [2:0] c,
                              input logic [8:0] imm, input logic [15:0] tgt);
    br_valid  = v;
    br_is_reg = is_reg;
    br_cond   = c;
    br_imm    = imm;
    br_reg    = tgt;
    step();
    br_valid  = 1'b0;
    br_is_reg = 1'b0;
    br_cond   = 3'd0;
    br_imm    = 9'd0;
    br_reg    = 16'h0000;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    clear_inputs();
    imem_ready = 1'b1;
    imem_rdata = 16'hDEAD;
    rst = 1'b1;
    step();
    step();
    n_cmp++;
    if (imem_req !== 1'b0) begin n_err++; $display("FAIL reset_req act=%b exp=0", imem_req); end
    n_cmp++;
    if (pc !== 16'h0000 || instr !== 16'h0000 || flags !== 3'b000) begin
      n_err++; $display("FAIL reset_regs pc=%h instr=%h flags=%b exp 0000/0000/000", pc, instr, flags);
    end
    n_cmp++;
    if ({instr_valid, br_taken, halted, fetch_err} !== 4'b0000) begin
      n_err++; $display("FAIL reset_outs act=%b exp=0000", {instr_valid, br_taken, halted, fetch_err});
    end
    clear_inputs();
    rst = 1'b0;
    #1;
    n_cmp++;
    if (imem_req !== 1'b1 || imem_addr !== 16'h0000) begin
      n_err++; $display("FAIL reset_release req=%b addr=%h exp 1/0000", imem_req, imem_addr);
    end
  endtask

  task automatic test_seq_fetch();
    apply_reset();
    for (int i = 0; i < 3; i++) begin
      n_cmp++;
      if (imem_req !== 1'b1 || instr_valid !== 1'b0 || imem_addr !== 16'(2 * i)) begin
        n_err++; $display("FAIL seq_fetch%0d req=%b iv=%b addr=%h exp 1/0/%h",
                          i, imem_req, instr_valid, imem_addr, 16'(2 * i));
      end
      drive_fetch(16'h1000 + 16'(i));
      n_cmp++;
      if (instr_valid !== 1'b1 || imem_req !== 1'b0 || instr !== 16'h1000 + 16'(i)) begin
        n_err++; $display("FAIL seq_issue%0d iv=%b req=%b instr=%h exp 1/0/%h",
                          i, instr_valid, imem_req, instr, 16'h1000 + 16'(i));
      end
      step();
    end
  endtask

  task automatic test_rel_branch();
    // Taken case: reach pc=0010 and set Z in the same cycle as the jump.
    apply_reset();
    drive_fetch(16'hA000);
    flag_we = 3'b100;
    flag_in = 3'b100;
    drive_branch(1'b1, 1'b1, 3'd7, 9'd0, 16'h0010);
    flag_we = 3'b000;
    flag_in = 3'b000;
    n_cmp++;
    if (pc !== 16'h0010 || br_taken !== 1'b1 || flags !== 3'b100) begin
      n_err++; $display("FAIL rel_setup pc=%h bt=%b flags=%b exp 0010/1/100", pc, br_taken, flags);
    end
    drive_fetch(16'hA001);
    drive_branch(1'b1, 1'b0, 3'd1, 9'h1FE, 16'h0000);
    n_cmp++;
    if (pc !== 16'h000E || imem_addr !== 16'h000E || br_taken !== 1'b1) begin
      n_err++; $display("FAIL beq_taken pc=%h addr=%h bt=%b exp 000E/000E/1", pc, imem_addr, br_taken);
    end
    step();
    n_cmp++;
    if (br_taken !== 1'b0) begin n_err++; $display("FAIL br_taken_pulse act=%b exp=0", br_taken); end

    // Not-taken case: Z stays 0.
    apply_reset();
    drive_fetch(16'hA000);
    drive_branch(1'b1, 1'b1, 3'd7, 9'd0, 16'h0010);
    drive_fetch(16'hA001);
    drive_branch(1'b1, 1'b0, 3'd1, 9'h1FE, 16'h0000);
    n_cmp++;
    if (pc !== 16'h0012 || br_taken !== 1'b0) begin
      n_err++; $display("FAIL beq_not_taken pc=%h bt=%b exp 0012/0", pc, br_taken);
    end
  endtask

  task automatic test_reg_wrap();
    apply_reset();
    drive_fetch(16'hB000);
    drive_branch(1'b1, 1'b1, 3'd7, 9'd0, 16'h1234);
    n_cmp++;
    if (imem_addr !== 16'h1234 || imem_req !== 1'b1 || br_taken !== 1'b1) begin
      n_err++; $display("FAIL reg_target addr=%h req=%b bt=%b exp 1234/1/1", imem_addr, imem_req, br_taken);
    end
    // br_valid low: an unconditional code must not redirect.
    drive_fetch(16'hB001);
    drive_branch(1'b0, 1'b1, 3'd7, 9'h055, 16'hFFFE);
    n_cmp++;
    if (imem_addr !== 16'h1236 || br_taken !== 1'b0) begin
      n_err++; $display("FAIL no_valid addr=%h bt=%b exp 1236/0", imem_addr, br_taken);
    end
    drive_fetch(16'hB002);
    drive_branch(1'b1, 1'b1, 3'd7, 9'd0, 16'hFFFE);
    drive_fetch(16'hB003);
    drive_branch(1'b0, 1'b0, 3'd0, 9'd0, 16'h0000);
    n_cmp++;
    if (imem_addr !== 16'h0000 || br_taken !== 1'b0) begin
      n_err++; $display("FAIL pc_wrap addr=%h bt=%b exp 0000/0", imem_addr, br_taken);
    end
  endtask

  task automatic test_stall_halt();
    apply_reset();
    drive_fetch(16'hBEEF);
    stall    = 1'b1;
    halt     = 1'b1;
    br_valid = 1'b1;
    br_cond  = 3'd7;
    for (int i = 0; i < 3; i++) begin
      step();
      n_cmp++;
      if (instr_valid !== 1'b1 || imem_req !== 1'b0 || pc !== 16'h0000 || instr !== 16'hBEEF) begin
        n_err++; $display("FAIL stall%0d iv=%b req=%b pc=%h instr=%h exp 1/0/0000/BEEF",
                          i, instr_valid, imem_req, pc, instr);
      end
    end
    stall     = 1'b0;
    br_is_reg = 1'b1;
    br_reg    = 16'h4444;
    step();
    clear_inputs();
    n_cmp++;
    if (halted !== 1'b1 || instr_valid !== 1'b0 || imem_req !== 1'b0 || pc !== 16'h0000 || br_taken !== 1'b0) begin
      n_err++; $display("FAIL halt h=%b iv=%b req=%b pc=%h bt=%b exp 1/0/0/0000/0",
                        halted, instr_valid, imem_req, pc, br_taken);
    end
    imem_ready = 1'b1;
    step();
    step();
    imem_ready = 1'b0;
    n_cmp++;
    if (halted !== 1'b1 || imem_req !== 1'b0 || pc !== 16'h0000) begin
      n_err++; $display("FAIL halt_parked h=%b req=%b pc=%h exp 1/0/0000", halted, imem_req, pc);
    end
  endtask

  task automatic test_flag_same_cycle();
    apply_reset();
    drive_fetch(16'hC000);
    flag_we = 3'b100;
    flag_in = 3'b100;
    drive_branch(1'b1, 1'b0, 3'd0, 9'h004, 16'h0000);
    flag_we = 3'b000;
    flag_in = 3'b000;
    n_cmp++;
    if (pc !== 16'h000A || br_taken !== 1'b1 || flags !== 3'b100) begin
      n_err++; $display("FAIL bne_old_flags pc=%h bt=%b flags=%b exp 000A/1/100", pc, br_taken, flags);
    end
    flag_we = 3'b010;
    flag_in = 3'b111;
    step();
    flag_we = 3'b000;
    flag_in = 3'b000;
    n_cmp++;
    if (flags !== 3'b110) begin n_err++; $display("FAIL flag_bit_we act=%b exp=110", flags); end
  endtask

  task automatic test_conds();
    for (int i = 0; i < 14; i++) begin
      logic [6:0]  e;
      logic [15:0] exp_pc;
      e = cond_tab[i];
      exp_pc = e[0] ? 16'h0022 : 16'h0002;
      apply_reset();
      flag_we = 3'b111;
      flag_in = e[3:1];
      drive_fetch(16'hD000);
      flag_we = 3'b000;
      flag_in = 3'b000;
      drive_branch(1'b1, 1'b0, e[6:4], 9'h010, 16'h0000);
      n_cmp++;
      if (pc !== exp_pc || br_taken !== e[0]) begin
        n_err++; $display("FAIL cond%0d c=%b f=%b pc=%h bt=%b exp %h/%b",
                          i, e[6:4], e[3:1], pc, br_taken, exp_pc, e[0]);
      end
    end
  endtask

  task automatic test_reset_mid();
    apply_reset();
    drive_fetch(16'hE000);
    drive_branch(1'b0, 1'b0, 3'd0, 9'd0, 16'h0000);
    flag_we = 3'b111;
    flag_in = 3'b101;
    drive_fetch(16'hABCD);
    flag_we = 3'b000;
    flag_in = 3'b000;
    rst = 1'b1;
    #1;
    n_cmp++;
    if (pc !== 16'h0000 || instr !== 16'h0000 || instr_valid !== 1'b0 || imem_req !== 1'b0 || flags !== 3'b000) begin
      n_err++; $display("FAIL reset_mid pc=%h instr=%h iv=%b req=%b flags=%b exp 0000/0000/0/0/000",
                        pc, instr, instr_valid, imem_req, flags);
    end
    step();
    rst = 1'b0;
    #1;
  endtask

  task automatic test_fetch_wait();
    apply_reset();
`ifdef FETCH_TIMEOUT_EN
    for (int i = 0; i < TO - 1; i++) step();
    n_cmp++;
    if (halted !== 1'b0 || fetch_err !== 1'b0 || imem_req !== 1'b1) begin
      n_err++; $display("FAIL timeout_early h=%b err=%b req=%b exp 0/0/1", halted, fetch_err, imem_req);
    end
    step();
    n_cmp++;
    if (halted !== 1'b1 || fetch_err !== 1'b1 || imem_req !== 1'b0) begin
      n_err++; $display("FAIL timeout_fire h=%b err=%b req=%b exp 1/1/0", halted, fetch_err, imem_req);
    end
    apply_reset();
    for (int i = 0; i < 5; i++) step();
    rst = 1'b1;
    #1;
    n_cmp++;
    if ({imem_req, instr_valid, halted, fetch_err, br_taken} !== 5'b00000) begin
      n_err++; $display("FAIL timeout_rst act=%b exp=00000", {imem_req, instr_valid, halted, fetch_err, br_taken});
    end
    step();
    rst = 1'b0;
    #1;
`else
    for (int i = 0; i < 2 * TO; i++) step();
    n_cmp++;
    if (halted !== 1'b0 || fetch_err !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 16'h0000) begin
      n_err++; $display("FAIL wait_forever h=%b err=%b req=%b addr=%h exp 0/0/1/0000",
                        halted, fetch_err, imem_req, imem_addr);
    end
    drive_fetch(16'hF00D);
    n_cmp++;
    if (instr_valid !== 1'b1 || instr !== 16'hF00D) begin
      n_err++; $display("FAIL late_ready iv=%b instr=%h exp 1/F00D", instr_valid, instr);
    end
`endif
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    clear_inputs();
    rst = 1'b1;
    test_reset();
    test_seq_fetch();
    test_rel_branch();
    test_reg_wrap();
    test_stall_halt();
    test_flag_same_cycle();
    test_conds();
    test_reset_mid();
    test_fetch_wait();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
